// File: rtl/swap_counter_sched.sv
// swap_counter_sched: round-robin scheduler sharing one W-bit incrementer
// between a lead counter X and a trail counter Y. It keeps Y <= X at all
// times and walks the pair through RUN -> SAT (X at MAX) -> DONE (both at MAX).
module swap_counter_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,      // asynchronous, active low
    input  logic         req_x,
    input  logic         req_y,
    input  logic         clr,
    output logic         gnt_x,
    output logic         gnt_y,
    output logic [W-1:0] x_val,
    output logic [W-1:0] y_val,
    output logic         sat,
    output logic         done,
    output logic         prop_ok
);

    localparam logic [W-1:0] MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SAT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] x_q, y_q;
    logic [W-1:0] x_d, y_d;
    logic         last_y_q, last_y_d;   // 1: Y was granted most recently
    logic         x_elig, y_elig;
    logic         grant_x, grant_y;
    logic [W-1:0] add_in, add_out;

    // Eligibility and round-robin arbitration from the current registers.
    // Y may only advance while strictly behind X, so Y == X stalls it.
    always_comb begin
        x_elig  = req_x && (x_q != MAX) && (state_q == ST_RUN);
        y_elig  = req_y && (y_q < x_q) && (state_q != ST_DONE);
        grant_x = x_elig && (!y_elig || last_y_q);
        grant_y = y_elig && (!x_elig || !last_y_q);
    end

    // Single shared incrementer: the operand is whichever counter is granted.
    always_comb begin
        add_in  = grant_x ? x_q : y_q;
        add_out = add_in + {{(W-1){1'b0}}, 1'b1};
    end

    // Next counter values, pointer and phase; clr overrides everything.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        last_y_d = last_y_q;
        state_d  = state_q;
        if (clr) begin
            x_d      = '0;
            y_d      = '0;
            last_y_d = 1'b1;
            state_d  = ST_RUN;
        end else begin
            if (grant_x) begin
                x_d      = add_out;
                last_y_d = 1'b0;
            end else if (grant_y) begin
                y_d      = add_out;
                last_y_d = 1'b1;
            end
            case (state_q)
                ST_RUN:  if (x_d == MAX) state_d = (y_d == MAX) ? ST_DONE : ST_SAT;
                ST_SAT:  if (y_d == MAX) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State register; grant pulses are the registered arbitration result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= '0;
            y_q      <= '0;
            last_y_q <= 1'b1;
            state_q  <= ST_RUN;
            gnt_x    <= 1'b0;
            gnt_y    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            last_y_q <= last_y_d;
            state_q  <= state_d;
            gnt_x    <= grant_x && !clr;
            gnt_y    <= grant_y && !clr;
        end
    end

    // Status outputs and the ordering property exported for formal.
    always_comb begin
        x_val   = x_q;
        y_val   = y_q;
        sat     = (state_q == ST_SAT);
        done    = (state_q == ST_DONE);
        prop_ok = !(y_q > x_q);
    end

endmodule
